// File: rtl/perceptron_multi_if.sv
// Handshake, weight-write and result bundle between the image source,
// the perceptron core and the classification consumer.
interface perceptron_multi_if #(
  parameter int WIDTH  = 25,
  parameter int NCLASS = 2,
  parameter int WBITS  = 2
);
  localparam int ACCW = $clog2(WIDTH * (2 ** WBITS - 1) + 1);
  localparam int IW   = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int CW   = ($clog2(NCLASS) > 0) ? $clog2(NCLASS) : 1;

  logic             start;
  logic [WIDTH-1:0] in;
  logic             wr_en;
  logic [CW-1:0]    wr_class;
  logic [IW-1:0]    wr_addr;
  logic [WBITS-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [CW-1:0]    class_id;
  logic [ACCW-1:0]  score;
  logic             class_valid;

  modport master (
    output start, in, wr_en, wr_class, wr_addr, wr_data,
    input  busy, done, class_id, score, class_valid
  );

  modport slave (
    input  start, in, wr_en, wr_class, wr_addr, wr_data,
    output busy, done, class_id, score, class_valid
  );
endinterface

// File: rtl/perceptron_multi.sv
// Multi-class serial perceptron: one pixel per cycle MAC across all classes,
// then a sequential thresholded argmax with lowest-index tie-break.
module perceptron_multi #(
  parameter int WIDTH  = 25,
  parameter int NCLASS = 2,
  parameter int WBITS  = 2,
  parameter int THRESH = 4
) (
  input logic clk,
  input logic rst,
  perceptron_multi_if.slave bus
);
  localparam int ACCW = $clog2(WIDTH * (2 ** WBITS - 1) + 1);
  localparam int IW   = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int CW   = ($clog2(NCLASS) > 0) ? $clog2(NCLASS) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(NCLASS - 1);
  // One extra bit so out-of-range write addresses/classes compare correctly.
  localparam logic [IW:0]   WIDTH_W  = (IW + 1)'(WIDTH);
  localparam logic [CW:0]   NCLASS_W = (CW + 1)'(NCLASS);

  typedef enum logic [1:0] {IDLE, MAC, ARG} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] img_reg;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    k;
  logic [ACCW-1:0]  acc_all [NCLASS];
  logic [ACCW-1:0]  best, best_next;
  logic [CW-1:0]    bid, bid_next;
  logic             done_reg;
  logic [CW-1:0]    class_id_reg;
  logic [ACCW-1:0]  score_reg;
  logic             class_valid_reg;
  logic             start_ok, wr_ok, arg_last;

  assign start_ok = (state == IDLE) && bus.start;
  assign wr_ok    = (state == IDLE) && bus.wr_en &&
                    ({1'b0, bus.wr_class} < NCLASS_W) &&
                    ({1'b0, bus.wr_addr} < WIDTH_W);
  assign arg_last = (state == ARG) && (k == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = MAC;
      MAC:     if (idx == IDX_LAST) state_next = ARG;
      ARG:     if (k == K_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = done_reg;
    bus.class_id    = class_id_reg;
    bus.score       = score_reg;
    bus.class_valid = class_valid_reg;
  end

  // Per-class weight row and accumulator; the write is seen by the MAC no
  // earlier than the edge after it commits, so write+start in IDLE is safe.
  genvar gi;
  generate
    for (gi = 0; gi < NCLASS; gi++) begin : g_class
      logic [WBITS-1:0] w [WIDTH];
      logic [ACCW-1:0]  acc_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < WIDTH; i++) w[i] <= '0;
        end else if (wr_ok && (bus.wr_class == CW'(gi))) begin
          w[bus.wr_addr] <= bus.wr_data;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                             acc_reg <= '0;
        else if (start_ok)                   acc_reg <= '0;
        else if (state == MAC && img_reg[idx]) acc_reg <= acc_reg + ACCW'(w[idx]);
      end

      assign acc_all[gi] = acc_reg;
    end
  endgenerate

  always_comb begin
    best_next = best;
    bid_next  = bid;
    if ((k == '0) || (acc_all[k] > best)) begin
      best_next = acc_all[k];
      bid_next  = k;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_reg <= '0;
      idx     <= '0;
      k       <= '0;
      best    <= '0;
      bid     <= '0;
    end else begin
      if (start_ok) begin
        img_reg <= bus.in;
        idx     <= '0;
      end else if (state == MAC) begin
        idx <= idx + 1'b1;
        if (idx == IDX_LAST) k <= '0;
      end else if (state == ARG) begin
        k    <= k + 1'b1;
        best <= best_next;
        bid  <= bid_next;
      end
    end
  end

  // Result registers only move on completion; a new start leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg        <= 1'b0;
      class_id_reg    <= '0;
      score_reg       <= '0;
      class_valid_reg <= 1'b0;
    end else begin
      done_reg <= arg_last;
      if (arg_last) begin
        class_id_reg    <= bid_next;
        score_reg       <= best_next;
        class_valid_reg <= (best_next >= ACCW'(THRESH));
      end
    end
  end
endmodule
